// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for both sides of the dual-clock FIFO: pointer width and Gray conversions.
// Pure functions, no state; used by the write- and read-side controllers.
package fifo_cdc_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros above the real pointer width convert to zeros, so callers zero-extend freely.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted most recently wins contention.
// Zero latency: grants are combinational from req/en and the last-grantee flop.
// en low blocks all grants; priority only moves when a grant is issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_q;   // 1: requester 1 was granted last

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = en & req[0] & (~req[1] | last_q);
        gnt[1] = en & req[1] & (~req[0] | ~last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side FIFO controller: round-robin write arbitration, write pointers, full/almost-full.
// Zero-cycle request-to-write; flags registered. Optional sticky overflow: FIFO_WR_OVF_STICKY_EN.
// Backpressure: no grant while o_full; requesters hold their request until granted.
module fifo_wr_arb_ctrl
    import fifo_cdc_pkg::*;
#(
    parameter  int MEM_DEPTH    = 8,
    parameter  int MEM_WIDTH    = 4,
    parameter  int AFULL_THRESH = 6,
    localparam int ADDR_W       = addr_w(MEM_DEPTH),
    localparam int PTR_W        = ADDR_W + 1
) (
    input  logic                 i_wr_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req0,
    input  logic [MEM_WIDTH-1:0] i_data0,
    output logic                 o_gnt0,
    input  logic                 i_req1,
    input  logic [MEM_WIDTH-1:0] i_data1,
    output logic                 o_gnt1,
    input  logic [ADDR_W:0]      i_rd_ptr_gray_sync,
    output logic                 o_wr_en,
    output logic [ADDR_W-1:0]    o_wr_addr,
    output logic [MEM_WIDTH-1:0] o_wr_data,
    output logic [ADDR_W:0]      o_wr_ptr_gray,
    output logic                 o_full,
    output logic                 o_almost_full
`ifdef FIFO_WR_OVF_STICKY_EN
   ,output logic                 o_overflow
`endif
);

    logic [1:0]       gnt;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] gnext;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] level;
    logic             full_next;

    // Reset also masks grants so nothing reaches the memory while reset is held.
    rr_arb2 u_arb (
        .clk   (i_wr_clk),
        .rst_n (i_rst_n),
        .req   ({i_req1, i_req0}),
        .en    (~o_full & i_rst_n),
        .gnt   (gnt)
    );

    assign o_gnt0    = gnt[0];
    assign o_gnt1    = gnt[1];
    assign o_wr_en   = |gnt;
    assign o_wr_addr = wbin[ADDR_W-1:0];

    always_comb begin
        o_wr_data = '0;
        if (gnt[0]) begin
            o_wr_data = i_data0;
        end else if (gnt[1]) begin
            o_wr_data = i_data1;
        end
    end

    // Flags compare against the pointer value that will be held after this edge.
    assign rptr      = i_rd_ptr_gray_sync;
    assign wbin_next = o_wr_en ? wbin + PTR_W'(1) : wbin;
    assign gnext     = PTR_W'(bin2gray(32'(wbin_next)));
    assign rbin      = PTR_W'(gray2bin(32'(rptr)));
    assign level     = wbin_next - rbin;
    assign full_next = (gnext == {~rptr[ADDR_W:ADDR_W-1], rptr[ADDR_W-2:0]});

    always_ff @(posedge i_wr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wbin          <= '0;
            o_wr_ptr_gray <= '0;
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            o_wr_ptr_gray <= gnext;
            o_full        <= full_next;
            o_almost_full <= (level >= PTR_W'(AFULL_THRESH));
        end
    end

`ifdef FIFO_WR_OVF_STICKY_EN
    always_ff @(posedge i_wr_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if ((i_req0 | i_req1) & o_full) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Directed bench for fifo_wr_arb_ctrl (8 entries, 4-bit data, almost-full at 6).
// Inputs change and outputs are sampled 1-2 ns after the rising edge.
module tb_fifo_wr_arb_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0  = 1'b0;
    logic       req1  = 1'b0;
    logic [3:0] d0    = 4'd0;
    logic [3:0] d1    = 4'd0;
    logic [3:0] rptr  = 4'd0;
    logic       gnt0;
    logic       gnt1;
    logic       wr_en;
    logic [2:0] addr;
    logic [3:0] wdat;
    logic [3:0] wgray;
    logic       full;
    logic       af;
`ifdef FIFO_WR_OVF_STICKY_EN
    logic       ovf;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    fifo_wr_arb_ctrl #(
        .MEM_DEPTH    (8),
        .MEM_WIDTH    (4),
        .AFULL_THRESH (6)
    ) dut (
        .i_wr_clk           (clk),
        .i_rst_n            (rst_n),
        .i_req0             (req0),
        .i_data0            (d0),
        .o_gnt0             (gnt0),
        .i_req1             (req1),
        .i_data1            (d1),
        .o_gnt1             (gnt1),
        .i_rd_ptr_gray_sync (rptr),
        .o_wr_en            (wr_en),
        .o_wr_addr          (addr),
        .o_wr_data          (wdat),
        .o_wr_ptr_gray      (wgray),
        .o_full             (full),
        .o_almost_full      (af)
`ifdef FIFO_WR_OVF_STICKY_EN
       ,.o_overflow         (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        rptr  = 4'd0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic int gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return int'(x ^ (x >> 1));
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_full", int'(full), 0);
        check("rst_af", int'(af), 0);
        check("rst_gray", int'(wgray), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_addr", int'(addr), 0);

        // Contention from empty: alternate 0,1,0,1
        rst_n = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        d0    = 4'hA;
        d1    = 4'h5;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_gnt0", int'(gnt0), (i % 2 == 0) ? 1 : 0);
            check("cont_gnt1", int'(gnt1), (i % 2 == 1) ? 1 : 0);
            check("cont_data", int'(wdat), (i % 2 == 0) ? 10 : 5);
            check("cont_addr", int'(addr), i);
            tick();
        end
        req1 = 1'b0;
        for (int i = 4; i < 6; i++) begin
            #1;
            check("solo_gnt0", int'(gnt0), 1);
            check("solo_addr", int'(addr), i);
            tick();
        end
        req0 = 1'b0;
        #1;
        check("six_af", int'(af), 1);
        check("idle_wr_en", int'(wr_en), 0);

        // Asynchronous reset mid-run with both requests high
        req0 = 1'b1;
        req1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt0", int'(gnt0), 0);
        check("arst_gnt1", int'(gnt1), 0);
        check("arst_wr_en", int'(wr_en), 0);
        check("arst_af", int'(af), 0);
        check("arst_gray", int'(wgray), 0);
        check("arst_addr", int'(addr), 0);
        check("arst_data", int'(wdat), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_gnt0", int'(gnt0), 1);
        tick();
        check("post_rst_gnt1", int'(gnt1), 1);

        // Fill to full with requester 0, read pointer parked at 0
        do_reset();
`ifdef FIFO_WR_OVF_STICKY_EN
        check("ovf_rst", int'(ovf), 0);
`endif
        req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d0 = 4'(i + 1);
            #1;
            check("fill_gnt0", int'(gnt0), 1);
            check("fill_addr", int'(addr), i);
            check("fill_data", int'(wdat), i + 1);
            tick();
            check("fill_af", int'(af), (i >= 5) ? 1 : 0);
            check("fill_full", int'(full), (i == 7) ? 1 : 0);
        end
        check("full_gray", int'(wgray), 12);
        check("full_no_gnt", int'(gnt0), 0);
        check("full_no_wr", int'(wr_en), 0);
        tick();
`ifdef FIFO_WR_OVF_STICKY_EN
        check("ovf_set", int'(ovf), 1);
`endif

        // Drain one entry: read pointer Gray 0 -> 1
        rptr = 4'b0001;
        #1;
        check("drain_gnt_blocked", int'(gnt0), 0);
        tick();
        check("drain_full_clr", int'(full), 0);
        check("drain_gnt0", int'(gnt0), 1);
        check("drain_addr", int'(addr), 0);
        tick();
        check("refull", int'(full), 1);
        check("refull_gray", int'(wgray), 13);
        check("refull_no_gnt", int'(gnt0), 0);
        req0 = 1'b0;
        rptr = 4'b0011;
        tick();
        tick();
        check("drain2_full", int'(full), 0);
`ifdef FIFO_WR_OVF_STICKY_EN
        check("ovf_sticky", int'(ovf), 1);
        do_reset();
        check("ovf_cleared", int'(ovf), 0);
`endif

        // Wrap: read pointer trails the write pointer by two
        do_reset();
        req0 = 1'b1;
        for (int m = 0; m < 20; m++) begin
            rptr = (m >= 2) ? 4'(gray(m - 2)) : 4'd0;
            d0   = 4'(m);
            #1;
            check("wrap_gnt0", int'(gnt0), 1);
            check("wrap_addr", int'(addr), m % 8);
            tick();
            check("wrap_full", int'(full), 0);
            check("wrap_af", int'(af), 0);
            check("wrap_gray", int'(wgray), gray(m + 1));
        end
        req0 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
